// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one Wishbone-style memory port between the instruction-fetch port
// (iport, read-only) and the data port (dport). One requester is granted at a
// time; the grant is held until the memory answers with ack or err, and the
// response is routed back to the granted port only. When both ports request
// from IDLE, the data port wins unless it was also granted last time.
//
// Optional feature: define ARB_TIMEOUT_EN to enable a BUSY-state watchdog that
// terminates a bus cycle with an error after TIMEOUT_CYCLES cycles without a
// response. Without it, BUSY waits indefinitely.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // instruction-fetch port
  input  logic                    iport_req_i,
  input  logic [ADDR_WIDTH-1:0]   iport_addr_i,
  output logic [DATA_WIDTH-1:0]   iport_rdata_o,
  output logic                    iport_ack_o,
  output logic                    iport_err_o,
  // data port
  input  logic                    dport_req_i,
  input  logic                    dport_we_i,
  input  logic [ADDR_WIDTH-1:0]   dport_addr_i,
  input  logic [DATA_WIDTH-1:0]   dport_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dport_sel_i,
  output logic [DATA_WIDTH-1:0]   dport_rdata_o,
  output logic                    dport_ack_o,
  output logic                    dport_err_o,
  // shared memory bus
  output logic                    mem_cyc_o,
  output logic                    mem_stb_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_sel_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ack_i,
  input  logic                    mem_err_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // The watchdog counter is at most 16 bits wide.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [1:0] state;
  logic       last_grant_d;   // 1: the previous grant went to the data port
  logic       grant_d;        // grant decision taken in IDLE
  logic       busy;
  logic       timeout_hit;
  logic       bus_fail;       // current BUSY cycle terminates with an error
  logic       bus_done;       // current BUSY cycle terminates this edge

  // Data port wins a tie unless it was served last; a lone request always wins.
  assign grant_d  = dport_req_i & (~iport_req_i | ~last_grant_d);
  assign busy     = (state == BUSY_I) || (state == BUSY_D);
  assign bus_fail = busy & (mem_err_i | timeout_hit);
  assign bus_done = busy & (mem_err_i | mem_ack_i | timeout_hit);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] busy_cnt;

  // Watchdog: held at zero outside BUSY so it starts clean on every grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_cnt <= '0;
    end else if (busy) begin
      busy_cnt <= busy_cnt + CNT_W'(1);
    end else begin
      busy_cnt <= '0;
    end
  end

  // The cycle in which the counter shows CNT_LAST is the last allowed BUSY cycle.
  assign timeout_hit = busy && (busy_cnt == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Arbitration FSM, bus request registers and one-cycle response pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      mem_cyc_o    <= 1'b0;
      mem_stb_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_sel_o    <= '0;
      iport_ack_o  <= 1'b0;
      iport_err_o  <= 1'b0;
      dport_ack_o  <= 1'b0;
      dport_err_o  <= 1'b0;
    end else begin
      iport_ack_o <= 1'b0;
      iport_err_o <= 1'b0;
      dport_ack_o <= 1'b0;
      dport_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (iport_req_i || dport_req_i) begin
            state        <= grant_d ? BUSY_D : BUSY_I;
            last_grant_d <= grant_d;
            mem_cyc_o    <= 1'b1;
            mem_stb_o    <= 1'b1;
            mem_addr_o   <= grant_d ? dport_addr_i : iport_addr_i;
            // Fetches are always full-word reads.
            mem_we_o     <= grant_d & dport_we_i;
            mem_wdata_o  <= grant_d ? dport_wdata_i : '0;
            mem_sel_o    <= grant_d ? dport_sel_i : '1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus_done) begin
            state     <= RESP;
            mem_cyc_o <= 1'b0;
            mem_stb_o <= 1'b0;
            if (state == BUSY_D) begin
              dport_err_o <= bus_fail;
              dport_ack_o <= ~bus_fail;
            end else begin
              iport_err_o <= bus_fail;
              iport_ack_o <= ~bus_fail;
            end
          end
        end
        default: begin
          // RESP lasts one cycle; req is not looked at until back in IDLE.
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data is captured only on a successful read; errors and writes keep the old word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      iport_rdata_o <= '0;
      dport_rdata_o <= '0;
    end else if (bus_done && !bus_fail) begin
      if (state == BUSY_I) begin
        iport_rdata_o <= mem_rdata_i;
      end else if (!mem_we_o) begin
        dport_rdata_o <= mem_rdata_i;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one Wishbone-style memory port between the instruction-fetch port (if_stage) and the data port (mem stage).
- Grants one requester at a time and holds the grant until the memory answers.
- Returns ack/err and read data to the granted requester only.
- Sits between the pipeline stages and the bus/memory model; the pipeline stalls on its own req until ack/err.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports; SEL width = DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- iport_req_i  in  1  instruction read request
- iport_addr_i  in  ADDR_WIDTH  fetch address
- iport_rdata_o  out  DATA_WIDTH  fetched word
- iport_ack_o  out  1  one-cycle completion pulse
- iport_err_o  out  1  one-cycle error pulse
- dport_req_i  in  1  data request
- dport_we_i  in  1  1 = write
- dport_addr_i  in  ADDR_WIDTH  data address
- dport_wdata_i  in  DATA_WIDTH  write data
- dport_sel_i  in  DATA_WIDTH/8  byte enables
- dport_rdata_o  out  DATA_WIDTH  load data
- dport_ack_o  out  1  one-cycle completion pulse
- dport_err_o  out  1  one-cycle error pulse
- mem_cyc_o, mem_stb_o  out  1  bus cycle/strobe
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_WIDTH  bus address
- mem_wdata_o  out  DATA_WIDTH  bus write data
- mem_sel_o  out  DATA_WIDTH/8  bus byte enables
- mem_rdata_i  in  DATA_WIDTH  bus read data
- mem_ack_i  in  1  bus acknowledge
- mem_err_i  in  1  bus error

Behaviour:
- All outputs registered. Reset: state IDLE, last_grant=I, all outputs 0.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, grant selection:
  - Only one req high: grant that port.
  - Both high: grant D, unless last_grant==D, then grant I (alternation, no starvation).
  - On grant: latch addr/we/wdata/sel (iport forces we=0, sel=all ones) and go to BUSY_x.
  - mem_cyc_o/mem_stb_o rise on the same edge that enters BUSY_x.
- BUSY_x:
  - Bus signals held stable.
  - mem_err_i sampled high: go to RESP and pulse x_err_o. mem_err_i wins over a simultaneous mem_ack_i.
  - Else mem_ack_i sampled high: go to RESP, pulse x_ack_o, register mem_rdata_i into x_rdata_o.
  - cyc/stb drop on that same edge.
- RESP: one cycle. Ack/err high for exactly this cycle; unconditional return to IDLE, so the requester's req is not re-sampled in its own ack cycle.
- x_rdata_o holds its value until the next completion on that port. Writes do not update dport_rdata_o.
- Minimum latency with a zero-wait memory: req sampled at edge 0 -> cyc/stb at edge 1 -> ack_o at edge 2 -> IDLE at edge 3.
- Requester contract: hold req/addr/data stable until ack/err.
  - If req drops mid-transaction, the bus cycle still completes and ack/err still pulse.
- mem_ack_i/mem_err_i while not BUSY: ignored.
- Reset asserted mid-transaction: cyc/stb/ack/err drop immediately (asynchronously); no response is ever delivered.
- Non-granted port: ack/err stay 0 throughout.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With it:
  - An 8..16-bit counter clears on entry to BUSY_x and increments each BUSY cycle.
  - When count reaches TIMEOUT_CYCLES without ack/err: drop cyc/stb, go to RESP, pulse x_err_o.
  - A late mem_ack_i is then ignored.
- Without it: no counter; BUSY waits indefinitely.

Test Plan:
- iport_req_i=1, addr=0x0000_0100; memory acks 0x0000_0013 with 0 wait -> mem_addr_o=0x100, mem_we_o=0 at edge 1; iport_ack_o pulse with rdata 0x13 at edge 2; dport outputs stay 0.
- dport write: addr=0x2000, wdata=0xDEADBEEF, sel=4'b0011, 2 wait states -> bus shows these values stably for 3 cycles; single dport_ack_o pulse.
- Both reqs held continuously for 4 transactions -> grant order D, I, D, I; each port sees exactly 2 ack pulses.
- Memory asserts mem_err_i and mem_ack_i together on a dport read -> dport_err_o=1, dport_ack_o=0, dport_rdata_o unchanged.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never acks an iport read -> iport_err_o after 8 BUSY cycles; a later mem_ack_i produces no pulse.
- rst_i driven low during BUSY_D -> mem_cyc_o=0 immediately; after release, no ack; a fresh iport request is served normally.
